// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit.
// Issues one request at a time to instruction memory, feeds the IF/ID
// register, and absorbs one instruction in a skid slot when decode stalls.
// Redirects (flush) may arrive in any state. A request that is still in
// flight at the time of a redirect is drained, and its data is thrown away.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] npc,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  input  logic        ifid_ready
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  // Word-aligned versions of the incoming addresses; the low two bits are ignored.
  logic [31:0] npc_al;
  logic [31:0] flush_al;
  logic        ifid_free;

  assign npc_al    = {npc[31:2], 2'b00};
  assign flush_al  = {flush_pc[31:2], 2'b00};
  assign ifid_free = !ifid_valid_q || ifid_ready;

  // The request comes from the state alone, so it is never combinationally tied to imem_ack.
  assign imem_req   = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign imem_addr  = req_addr_q;
  assign pc         = pc_q;
  assign ifid_valid = ifid_valid_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_pc    = ifid_pc_q;

  // Next-state logic: FSM, PC/request address, IF/ID register and skid slot.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    // When decode consumes the IF/ID entry and nothing new is loaded, the entry empties.
    ifid_valid_d = ifid_valid_q && !ifid_ready;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    case (state_q)
      ST_IDLE: begin
        state_d    = ST_FETCH;
        req_addr_d = pc_q;
        if (flush) begin
          pc_d         = flush_al;
          req_addr_d   = flush_al;
          ifid_valid_d = 1'b0;
          skid_valid_d = 1'b0;
        end
      end

      ST_FETCH: begin
        if (flush) begin
          pc_d         = flush_al;
          ifid_valid_d = 1'b0;
          skid_valid_d = 1'b0;
          if (imem_ack) begin
            // The returned word belongs to the old path, so drop it and restart right away.
            req_addr_d = flush_al;
          end else begin
            // The memory still owes a response to the old address. Wait for it without changing the address.
            state_d = ST_DRAIN;
          end
        end else if (imem_ack) begin
          pc_d = npc_al;
          if (ifid_free) begin
            ifid_valid_d = 1'b1;
            ifid_instr_d = imem_rdata;
            ifid_pc_d    = req_addr_q;
            req_addr_d   = npc_al;
          end else begin
            skid_valid_d = 1'b1;
            skid_instr_d = imem_rdata;
            skid_pc_d    = req_addr_q;
            state_d      = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        if (flush) begin
          pc_d         = flush_al;
          req_addr_d   = flush_al;
          ifid_valid_d = 1'b0;
          skid_valid_d = 1'b0;
          state_d      = ST_FETCH;
        end else if (ifid_ready && skid_valid_q) begin
          ifid_valid_d = 1'b1;
          ifid_instr_d = skid_instr_q;
          ifid_pc_d    = skid_pc_q;
          skid_valid_d = 1'b0;
          req_addr_d   = pc_q;
          state_d      = ST_FETCH;
        end
      end

      ST_DRAIN: begin
        if (flush) begin
          pc_d         = flush_al;
          ifid_valid_d = 1'b0;
          skid_valid_d = 1'b0;
        end
        if (imem_ack) begin
          // Drop the stale word and restart at the most recent redirect target.
          req_addr_d = pc_d;
          state_d    = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any in-flight request without draining it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= 32'd0;
      ifid_pc_q    <= 32'd0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= 32'd0;
      skid_pc_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: runs directed scenarios and a randomized stream against ifu_fetch.
// Memory contents are a fixed function of the address. The reference model is
// the sequence of instruction addresses that decode should receive. That
// sequence starts at the reset PC and steps by 4 on each delivery. A redirect
// moves it to the aligned redirect target.
module tb_ifu_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] npc;
  logic        flush;
  logic [31:0] flush_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic        ifid_ready;

  logic [1:0]  npc_junk;
  logic [31:0] junk_word;

  int n_checks;
  int n_pass;

  ifu_fetch #(.RESET_PC(32'h0000_3000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .npc        (npc),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .ifid_valid (ifid_valid),
    .ifid_instr (ifid_instr),
    .ifid_pc    (ifid_pc),
    .ifid_ready (ifid_ready)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  // The npc block adds 4. Junk in the low bits checks that the DUT ignores them.
  assign npc        = pc + 32'd4 + {30'd0, npc_junk};
  assign imem_rdata = imem_ack ? memf(imem_addr) : junk_word;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; imem_ack = 1'b0; ifid_ready = 1'b1;
    flush_pc = 32'd0; npc_junk = 2'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; flush = 1'b0; imem_ack = 1'b0; ifid_ready = 1'b0;
    flush_pc = 32'd0; npc_junk = 2'd0; junk_word = 32'hDEAD_BEEF;
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b0) $display("FAIL reset_req got %b want 0", imem_req); else n_pass++;
    n_checks++; if (pc !== 32'h3000) $display("FAIL reset_pc got %h want 00003000", pc); else n_pass++;
    n_checks++; if (imem_addr !== 32'h3000) $display("FAIL reset_addr got %h want 00003000", imem_addr); else n_pass++;
    n_checks++; if (ifid_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", ifid_valid); else n_pass++;
    n_checks++; if (ifid_instr !== 32'd0) $display("FAIL reset_instr got %h want 0", ifid_instr); else n_pass++;
    n_checks++; if (ifid_pc !== 32'd0) $display("FAIL reset_ifid_pc got %h want 0", ifid_pc); else n_pass++;
    $display("reset: outputs checked");
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    do_reset();
    imem_ack = 1'b1; ifid_ready = 1'b1;
    tick();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000)
      $display("FAIL stream_first_req got req=%b addr=%h want 1/00003000", imem_req, imem_addr); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp = 32'h3000 + 32'(4 * i);
      n_checks++; if (ifid_valid !== 1'b1 || ifid_pc !== exp || ifid_instr !== memf(exp))
        $display("FAIL stream_deliver%0d got v=%b pc=%h instr=%h want 1/%h/%h", i, ifid_valid, ifid_pc, ifid_instr, exp, memf(exp));
      else n_pass++;
      $display("stream: delivered pc=%h", ifid_pc);
    end
  endtask

  task automatic test_stall();
    do_reset();
    imem_ack = 1'b1; ifid_ready = 1'b1;
    tick(); tick();
    ifid_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (imem_req !== 1'b0 || ifid_pc !== 32'h3000 || ifid_valid !== 1'b1)
        $display("FAIL stall_hold%0d got req=%b v=%b pc=%h want 0/1/00003000", i, imem_req, ifid_valid, ifid_pc);
      else n_pass++;
    end
    ifid_ready = 1'b1;
    tick();
    n_checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h3004 || ifid_instr !== memf(32'h3004))
      $display("FAIL stall_release got v=%b pc=%h instr=%h want 1/00003004", ifid_valid, ifid_pc, ifid_instr); else n_pass++;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3008)
      $display("FAIL stall_refetch got req=%b addr=%h want 1/00003008", imem_req, imem_addr); else n_pass++;
    tick();
    n_checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h3008)
      $display("FAIL stall_next got v=%b pc=%h want 1/00003008", ifid_valid, ifid_pc); else n_pass++;
    $display("stall: skid released pc=3004 then 3008");
  endtask

  task automatic test_flush_outstanding();
    do_reset();
    imem_ack = 1'b1; ifid_ready = 1'b1;
    tick(); tick(); tick();
    imem_ack = 1'b0; flush = 1'b1; flush_pc = 32'h0000_4000;
    tick();
    flush = 1'b0;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3008 || ifid_valid !== 1'b0 || pc !== 32'h4000)
      $display("FAIL drain_enter got req=%b addr=%h v=%b pc=%h want 1/00003008/0/00004000", imem_req, imem_addr, ifid_valid, pc);
    else n_pass++;
    tick();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3008)
      $display("FAIL drain_hold got req=%b addr=%h want 1/00003008", imem_req, imem_addr); else n_pass++;
    imem_ack = 1'b1;
    tick();
    n_checks++; if (ifid_valid !== 1'b0 || imem_addr !== 32'h4000)
      $display("FAIL drain_exit got v=%b addr=%h want 0/00004000", ifid_valid, imem_addr); else n_pass++;
    tick();
    n_checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h4000 || ifid_instr !== memf(32'h4000))
      $display("FAIL drain_deliver got v=%b pc=%h want 1/00004000", ifid_valid, ifid_pc); else n_pass++;
    $display("flush_outstanding: stale 3008 dropped, delivered %h", ifid_pc);
  endtask

  task automatic test_flush_ack();
    do_reset();
    imem_ack = 1'b1; ifid_ready = 1'b1;
    tick(); tick();
    flush = 1'b1; flush_pc = 32'h0000_5002;
    tick();
    flush = 1'b0;
    n_checks++; if (ifid_valid !== 1'b0 || imem_addr !== 32'h5000 || pc !== 32'h5000)
      $display("FAIL flush_ack got v=%b addr=%h pc=%h want 0/00005000/00005000", ifid_valid, imem_addr, pc); else n_pass++;
    tick();
    n_checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h5000)
      $display("FAIL flush_ack_deliver got v=%b pc=%h want 1/00005000", ifid_valid, ifid_pc); else n_pass++;
    $display("flush_ack: redirected to %h", ifid_pc);
  endtask

  task automatic test_reset_mid();
    do_reset();
    imem_ack = 1'b1; ifid_ready = 1'b1;
    tick(); tick(); tick();
    imem_ack = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b0 || ifid_valid !== 1'b0 || ifid_pc !== 32'd0 || ifid_instr !== 32'd0 ||
                    pc !== 32'h3000 || imem_addr !== 32'h3000)
      $display("FAIL reset_mid got req=%b v=%b ipc=%h instr=%h pc=%h addr=%h want 0/0/0/0/3000/3000",
               imem_req, ifid_valid, ifid_pc, ifid_instr, pc, imem_addr);
    else n_pass++;
    imem_ack = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000 || ifid_valid !== 1'b0)
      $display("FAIL reset_mid_restart got req=%b addr=%h v=%b want 1/00003000/0", imem_req, imem_addr, ifid_valid); else n_pass++;
    tick();
    n_checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h3000)
      $display("FAIL reset_mid_deliver got v=%b pc=%h want 1/00003000", ifid_valid, ifid_pc); else n_pass++;
    $display("reset_mid: restarted at %h", ifid_pc);
  endtask

  task automatic test_ack_delay();
    do_reset();
    imem_ack = 1'b0; ifid_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000 || ifid_valid !== 1'b0)
        $display("FAIL ack_delay_wait%0d got req=%b addr=%h v=%b want 1/00003000/0", i, imem_req, imem_addr, ifid_valid);
      else n_pass++;
    end
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    n_checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h3000)
      $display("FAIL ack_delay_deliver got v=%b pc=%h want 1/00003000", ifid_valid, ifid_pc); else n_pass++;
    $display("ack_delay: delivered %h after 4 wait cycles", ifid_pc);
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic        prev_req, prev_ack;
    logic [31:0] prev_addr;
    int          delivered;
    do_reset();
    exp_pc = 32'h3000;
    prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 32'd0;
    delivered = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      tick();
      if (prev_req && !prev_ack) begin
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== prev_addr)
          $display("FAIL rand_addr_stable cyc=%0d got req=%b addr=%h want 1/%h", cyc, imem_req, imem_addr, prev_addr);
        else n_pass++;
      end
      if (pc[1:0] !== 2'b00 || imem_addr[1:0] !== 2'b00 || ifid_pc[1:0] !== 2'b00) begin
        n_checks++; n_pass += 0;
        $display("FAIL rand_align cyc=%0d got pc=%h addr=%h ipc=%h want low bits 00", cyc, pc, imem_addr, ifid_pc);
      end
      imem_ack   = ($urandom_range(0, 1) == 1);
      ifid_ready = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 15) == 0);
      flush_pc   = {16'd0, 16'($urandom())};
      npc_junk   = 2'($urandom());
      junk_word  = $urandom();
      if (ifid_valid && ifid_ready) begin
        n_checks++; if (ifid_pc !== exp_pc || ifid_instr !== memf(exp_pc))
          $display("FAIL rand_deliver cyc=%0d got pc=%h instr=%h want %h/%h", cyc, ifid_pc, ifid_instr, exp_pc, memf(exp_pc));
        else n_pass++;
        $display("rand: cyc=%0d delivered pc=%h instr=%h", cyc, ifid_pc, ifid_instr);
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (flush) exp_pc = {flush_pc[31:2], 2'b00};
      prev_req  = imem_req;
      prev_ack  = imem_ack;
      prev_addr = imem_addr;
    end
    flush = 1'b0; imem_ack = 1'b0;
    n_checks++; if (delivered < 150)
      $display("FAIL rand_progress got %0d deliveries want at least 150", delivered); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_stream();
    test_stall();
    test_flush_outstanding();
    test_flush_ack();
    test_reset_mid();
    test_ack_delay();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
